// File: rtl/pipe_pkg.sv
// Shared types and constants for the valid/ready pipeline stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_t;

  // A zeroed payload decodes as a NOP downstream; replicated to DATA_W at use.
  localparam logic PIPE_NOP_BIT = 1'b0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised valid/ready pipeline register with optional 2-entry skid buffer,
// flush-to-NOP and a saturating stall-cycle counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              cnt_clr
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              in_xfer, out_xfer;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = out_valid ? main_q : {DATA_W{PIPE_NOP_BIT}};
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] skid_q, skid_d;
      logic              rdy_q;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
          ST_EMPTY: begin
            if (in_xfer) begin
              state_d = ST_ONE;
              main_d  = in_data;
            end
          end
          ST_ONE: begin
            if (in_xfer && out_xfer) begin
              main_d = in_data;
            end else if (in_xfer) begin
              state_d = ST_FULL;
              skid_d  = in_data;
            end else if (out_xfer) begin
              state_d = ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (out_xfer) begin
              state_d = ST_ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
          state_d = ST_EMPTY;
          main_d  = {DATA_W{PIPE_NOP_BIT}};
          skid_d  = {DATA_W{PIPE_NOP_BIT}};
        end
      end

      // in_ready is a pure flop output so upstream sees no combinational path.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          skid_q <= '0;
          rdy_q  <= 1'b0;
        end else begin
          skid_q <= skid_d;
          rdy_q  <= (state_d != ST_FULL);
        end
      end

      assign in_ready = rdy_q;
    end else begin : g_single
      logic alive_q;

      // Holds in_ready low until the first edge after reset release.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alive_q <= 1'b0;
        else        alive_q <= 1'b1;
      end

      assign in_ready = alive_q && (!out_valid || out_ready);

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        case (state_q)
          ST_EMPTY: begin
            if (in_xfer) begin
              state_d = ST_ONE;
              main_d  = in_data;
            end
          end
          ST_ONE: begin
            if (in_xfer) begin
              main_d = in_data;
            end else if (out_xfer) begin
              state_d = ST_EMPTY;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
          state_d = ST_EMPTY;
          main_d  = {DATA_W{PIPE_NOP_BIT}};
        end
      end
    end
  endgenerate

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid && !out_ready),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance,
// selected by 'mode'; the driver queues accepted payloads, the monitor pops them.
module tb_pipe_stage_skid;

  localparam int DW = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, in_valid, out_ready, cnt_clr, mode;
  logic [DW-1:0] in_data;

  logic          in_ready1, out_valid1, in_ready0, out_valid0;
  logic [DW-1:0] out_data1, out_data0;
  logic [CW-1:0] stall_cnt1, stall_cnt0;

  logic          in_ready_m, out_valid_m;
  logic [DW-1:0] out_data_m;
  logic [CW-1:0] stall_m;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            n_out = 0;
  int            cyc   = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_stage_skid #(.DATA_W(DW), .SKID(1), .CNT_W(CW)) u_dut_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid && mode), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .stall_cnt(stall_cnt1), .cnt_clr(cnt_clr)
  );

  pipe_stage_skid #(.DATA_W(DW), .SKID(0), .CNT_W(CW)) u_dut_single (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid && !mode), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .stall_cnt(stall_cnt0), .cnt_clr(cnt_clr)
  );

  assign in_ready_m  = mode ? in_ready1  : in_ready0;
  assign out_valid_m = mode ? out_valid1 : out_valid0;
  assign out_data_m  = mode ? out_data1  : out_data0;
  assign stall_m     = mode ? stall_cnt1 : stall_cnt0;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (mode=%0d): got %0h expected %0h", nm, mode, act, exp);
    end
  endtask

  // Monitor: compares every delivered payload and the NOP masking of idle output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid_m && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out (mode=%0d): got %0h expected nothing", mode, out_data_m);
        end else begin
          check("out_data", out_data_m, exp_q.pop_front());
        end
      end
      if (!out_valid_m) check("idle_zero", out_data_m, '0);
      if (flush) exp_q.delete();
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send(input logic [DW-1:0] v);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = v;
    forever begin
      @(negedge clk);
      if (in_ready_m) begin
        if (!flush) exp_q.push_back(v);
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      t++;
      if (t > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout (mode=%0d): in_ready stuck low, expected acceptance of %0h", mode, v);
        break;
      end
    end
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    cycles(1);
    cnt_clr = 1'b0;
  endtask

  task automatic run_stream();
    int t0, o0;
    clear_cnt();
    out_ready = 1'b1;
    t0 = cyc;
    o0 = n_out;
    for (int i = 1; i <= 100; i++) send(DW'(i));
    idle();
    check("stream_cycles", DW'(cyc - t0), DW'(100));
    cycles(2);
    check("stream_count", DW'(n_out - o0), DW'(100));
    check("stream_stall", DW'(stall_m), '0);
    check("stream_drained", DW'(exp_q.size()), '0);
  endtask

  task automatic run_backpressure();
    int o0;
    clear_cnt();
    out_ready = 1'b0;
    o0 = n_out;
    fork
      begin
        send(64'hA);
        send(64'hB);
        send(64'hC);
        idle();
      end
      begin
        cycles(3);
        check("bp_in_ready_low", DW'(in_ready_m), '0);
        cycles(3);
        out_ready = 1'b1;
        #1;
        // Single-entry mode reacts combinationally; skid mode is still FULL.
        check("bp_in_ready_release", DW'(in_ready_m), mode ? DW'(0) : DW'(1));
      end
    join
    cycles(4);
    check("bp_count", DW'(n_out - o0), DW'(3));
    check("bp_stall", DW'(stall_m), DW'(5));
    check("bp_drained", DW'(exp_q.size()), '0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0;
    rst_n = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b0; mode = 1'b1;
    idle();
    #2;
    check("rst_in_ready1", DW'(in_ready1), '0);
    check("rst_in_ready0", DW'(in_ready0), '0);
    check("rst_out_valid", DW'(out_valid1), '0);
    check("rst_stall", DW'(stall_cnt1), '0);
    #21 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready1", DW'(in_ready1), DW'(1));
    check("post_rst_in_ready0", DW'(in_ready0), DW'(1));

    // Skid mode
    mode = 1'b1;
    run_stream();
    run_backpressure();

    // Flush while FULL with C offered
    out_ready = 1'b0;
    send(64'hA1);
    send(64'hB2);
    o0 = n_out;
    flush = 1'b1; in_valid = 1'b1; in_data = 64'hC3;
    cycles(1);
    flush = 1'b0;
    idle();
    check("flush_out_valid", DW'(out_valid_m), '0);
    check("flush_out_data", out_data_m, '0);
    check("flush_in_ready", DW'(in_ready_m), DW'(1));
    out_ready = 1'b1;
    cycles(3);
    check("flush_no_output", DW'(n_out - o0), '0);

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    send(64'hD4);
    send(64'hE5);
    idle();
    cycles(1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", DW'(out_valid_m), '0);
    check("arst_out_data", out_data_m, '0);
    check("arst_stall", DW'(stall_m), '0);
    check("arst_in_ready", DW'(in_ready_m), '0);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_release_in_ready", DW'(in_ready_m), DW'(1));

    // Counter saturation and clear
    clear_cnt();
    send(64'hF6);
    idle();
    cycles(70000);
    check("cnt_saturate", DW'(stall_m), DW'(65535));
    cnt_clr = 1'b1;
    cycles(1);
    check("cnt_clear", DW'(stall_m), '0);
    cnt_clr = 1'b0;
    out_ready = 1'b1;
    cycles(2);
    check("cnt_drained", DW'(exp_q.size()), '0);

    // Single-entry mode
    mode = 1'b0;
    cycles(1);
    run_stream();
    run_backpressure();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
